// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard scoreboard: decode/EX/MEM/WB register and control
// taps in, stall/forward/scoreboard status out.
interface hazard_scoreboard_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned NREG = 2 ** AW;

  logic            valid_d;
  logic [AW-1:0]   rs_d, rt_d, wr_reg_d;
  logic            use_rs_d, use_rt_d, br_rs_d, br_rt_d, reg_write_d, md_d;
  logic [AW-1:0]   rs_e, rt_e, wr_reg_e;
  logic            reg_write_e, mem_to_reg_e;
  logic [AW-1:0]   rt_m, wr_reg_m;
  logic            reg_write_m, mem_to_reg_m, link_m;
  logic [AW-1:0]   wr_reg_w;
  logic            reg_write_w;
  logic            md_wb_valid;
  logic [AW-1:0]   md_wb_reg;
  logic            clr_cnt;
  logic            stall_f, stall_d, flush_e;
  logic [1:0]      fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic            fwd_m;
  logic            md_busy;
  logic [NREG-1:0] sb_pending;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output valid_d, rs_d, rt_d, wr_reg_d, use_rs_d, use_rt_d, br_rs_d, br_rt_d, reg_write_d,
           md_d, rs_e, rt_e, wr_reg_e, reg_write_e, mem_to_reg_e, rt_m, wr_reg_m, reg_write_m,
           mem_to_reg_m, link_m, wr_reg_w, reg_write_w, md_wb_valid, md_wb_reg, clr_cnt,
    input  stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, fwd_m, md_busy,
           sb_pending, stall_cycles
  );

  modport slave (
    input  valid_d, rs_d, rt_d, wr_reg_d, use_rs_d, use_rt_d, br_rs_d, br_rt_d, reg_write_d,
           md_d, rs_e, rt_e, wr_reg_e, reg_write_e, mem_to_reg_e, rt_m, wr_reg_m, reg_write_m,
           mem_to_reg_m, link_m, wr_reg_w, reg_write_w, md_wb_valid, md_wb_reg, clr_cnt,
    output stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, fwd_m, md_busy,
           sb_pending, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard detection, forwarding selects and multi-cycle-unit scoreboard for a 5-stage pipeline,
// with a saturating stall-cycle performance counter.
module hazard_scoreboard #(
  parameter int unsigned AW     = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned MdW  = 8;
  localparam logic [MdW-1:0] MdLat = MdW'(MD_LAT);

  logic [NREG-1:0]  sb_q, sb_d;
  logic [MdW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             md_busy, stall, issue, rs_used, rt_used;
  logic             h1, h2, h3, h4, h5;

  // Register 0 is hard-wired zero, so it never participates in a match.
  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  function automatic logic [1:0] fwd_id_sel(input logic [AW-1:0] src, input logic [AW-1:0] wr_m,
                                            input logic rw_m, input logic mtr_m, input logic lnk_m,
                                            input logic [AW-1:0] wr_w, input logic rw_w);
    if (hit(src, wr_m) && rw_m && lnk_m)       return 2'b11;
    else if (hit(src, wr_m) && rw_m && !mtr_m) return 2'b01;
    else if (hit(src, wr_w) && rw_w)           return 2'b10;
    else                                       return 2'b00;
  endfunction

  function automatic logic [1:0] fwd_ex_sel(input logic [AW-1:0] src, input logic [AW-1:0] wr_m,
                                            input logic rw_m, input logic [AW-1:0] wr_w,
                                            input logic rw_w);
    if (hit(src, wr_m) && rw_m)      return 2'b01;
    else if (hit(src, wr_w) && rw_w) return 2'b10;
    else                             return 2'b00;
  endfunction

  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    rs_used = bus.use_rs_d | bus.br_rs_d;
    rt_used = bus.use_rt_d | bus.br_rt_d;
    h1 = bus.mem_to_reg_e & bus.reg_write_e &
         ((rs_used & hit(bus.rs_d, bus.wr_reg_e)) | (rt_used & hit(bus.rt_d, bus.wr_reg_e)));
    h2 = bus.reg_write_e &
         ((bus.br_rs_d & hit(bus.rs_d, bus.wr_reg_e)) |
          (bus.br_rt_d & hit(bus.rt_d, bus.wr_reg_e)));
    h3 = bus.reg_write_m & bus.mem_to_reg_m &
         ((bus.br_rs_d & hit(bus.rs_d, bus.wr_reg_m)) |
          (bus.br_rt_d & hit(bus.rt_d, bus.wr_reg_m)));
    // Registered scoreboard only: a same-cycle md writeback does not release the stall.
    h4 = (rs_used & (bus.rs_d != '0) & sb_q[bus.rs_d]) |
         (rt_used & (bus.rt_d != '0) & sb_q[bus.rt_d]) |
         (bus.reg_write_d & (bus.wr_reg_d != '0) & sb_q[bus.wr_reg_d]);
    h5 = bus.md_d & md_busy;
    stall = ~rst & bus.valid_d & (h1 | h2 | h3 | h4 | h5);
    issue = bus.valid_d & ~stall;
  end

  always_comb begin
    sb_d = sb_q;
    if (bus.md_wb_valid) sb_d[bus.md_wb_reg] = 1'b0;
    if (issue && bus.md_d && bus.reg_write_d && (bus.wr_reg_d != '0)) sb_d[bus.wr_reg_d] = 1'b1;

    if (issue && bus.md_d) md_cnt_d = MdLat;
    else if (md_busy)      md_cnt_d = md_cnt_q - 1'b1;
    else                   md_cnt_d = md_cnt_q;

    if (bus.clr_cnt)                  stall_cnt_d = '0;
    else if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    else                              stall_cnt_d = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_f      = stall;
  assign bus.stall_d      = stall;
  assign bus.flush_e      = stall;
  assign bus.md_busy      = md_busy;
  assign bus.sb_pending   = sb_q;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.fwd_a_d = fwd_id_sel(bus.rs_d, bus.wr_reg_m, bus.reg_write_m, bus.mem_to_reg_m,
                                  bus.link_m, bus.wr_reg_w, bus.reg_write_w);
  assign bus.fwd_b_d = fwd_id_sel(bus.rt_d, bus.wr_reg_m, bus.reg_write_m, bus.mem_to_reg_m,
                                  bus.link_m, bus.wr_reg_w, bus.reg_write_w);
  assign bus.fwd_a_e = fwd_ex_sel(bus.rs_e, bus.wr_reg_m, bus.reg_write_m, bus.wr_reg_w,
                                  bus.reg_write_w);
  assign bus.fwd_b_e = fwd_ex_sel(bus.rt_e, bus.wr_reg_m, bus.reg_write_m, bus.wr_reg_w,
                                  bus.reg_write_w);
  assign bus.fwd_m   = (bus.rt_m == bus.wr_reg_w) & bus.reg_write_w & (bus.wr_reg_w != '0);
endmodule
